// File: rtl/clk_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_en_pkg
//  Purpose  : Shared types and helpers for the clock-enable generator.
//  Revision : 1.0  initial release
// ============================================================================
package clk_en_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } sup_state_e;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_channel.sv
`default_nettype none
// ============================================================================
//  Module   : clk_en_channel
//  Purpose  : One divided clock-enable channel: down-counter, divisor register
//             and glitch-free divisor update.
//  Revision : 1.0  initial release
// ============================================================================
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             realign_i,
    input  logic             apply_req_i,
    input  logic [CNT_W-1:0] new_div_i,
    output logic             ce_o,
    output logic             ce_mid_o,
    output logic [CNT_W-1:0] div_o,
    output logic             applied_o
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;

    logic w_on;
    logic w_zero;
    logic w_multi;
    logic w_strobe;

    assign w_on     = (div_q != '0);
    assign w_zero   = (cnt_q == '0);
    assign w_multi  = |div_q[CNT_W-1:1];
    assign w_strobe = run_i && w_on && w_zero;

    assign ce_o     = w_strobe;
    assign ce_mid_o = run_i && w_multi && (cnt_q == (div_q >> 1));

    // An active running channel only takes a new divisor on its own strobe,
    // so the period in progress always completes.
    assign applied_o = apply_req_i && (!run_i || !w_on || w_zero);

    // The new divisor is visible on the apply cycle itself.
    assign div_o = applied_o ? new_div_i : div_q;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (applied_o) begin
            div_d = new_div_i;
        end
        if (!run_i || realign_i) begin
            cnt_d = '0;
        end else if (applied_o) begin
            cnt_d = (new_div_i == '0) ? '0 : (new_div_i - c_ONE);
        end else if (!w_on) begin
            cnt_d = '0;
        end else if (w_zero) begin
            cnt_d = div_q - c_ONE;
        end else begin
            cnt_d = cnt_q - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DIV_RST;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_enable_gen
//  Purpose  : NUM_CH divided clock-enable strobes from one master clock, with
//             runtime divisors, half-period strobes and PLL-lock supervision.
//  Revision : 1.0  initial release
// ============================================================================
module clk_enable_gen
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT    = {8'd8, 8'd4, 8'd2, 8'd1},
    parameter int                      LOCK_CYCLES = 16,
    localparam int                     CH_W        = ch_width(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic                      realign,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [CNT_W-1:0]          cfg_div,
    output logic                      cfg_err,
    output logic                      ready,
    output logic [NUM_CH-1:0]         ce,
    output logic [NUM_CH-1:0]         ce_mid,
    output logic [NUM_CH*CNT_W-1:0]   div_cur
);

    localparam int                    c_STAB_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_STAB_W-1:0]   c_STAB_ONE = c_STAB_W'(1);
    localparam logic [c_STAB_W-1:0]   c_LOCK     = c_STAB_W'(LOCK_CYCLES);

    // ------------------------------------------------------------------
    // Lock synchroniser and supervisor
    // ------------------------------------------------------------------
    logic [1:0]          sync_q;
    sup_state_e          state_q;
    logic [c_STAB_W-1:0] stab_q;
    logic                ready_q;
    logic                w_lk_s;
    logic                w_run;

    assign w_lk_s = sync_q[1];
    assign w_run  = (state_q == RUN);
    assign ready  = ready_q;

    // ready_q is loaded with the next state's RUN-ness so it tracks state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pll_locked};
            ready_q <= 1'b0;
            case (state_q)
                WAIT_LOCK: begin
                    if (w_lk_s) begin
                        state_q <= STABLE;
                        stab_q  <= c_STAB_ONE;
                    end
                end
                STABLE: begin
                    if (!w_lk_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (stab_q == c_LOCK) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        stab_q <= stab_q + c_STAB_ONE;
                    end
                end
                RUN: begin
                    if (!w_lk_s) begin
                        state_q <= WAIT_LOCK;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Configuration handshake and single pending slot
    // ------------------------------------------------------------------
    logic              pend_vld_q;
    logic [CH_W-1:0]   pend_ch_q;
    logic [CNT_W-1:0]  pend_div_q;
    logic              cfg_err_q;
    logic              w_accept;
    logic              w_bad;
    logic [NUM_CH-1:0] w_applied;
    logic              w_any_applied;

    assign cfg_ready     = ~pend_vld_q;
    assign cfg_err       = cfg_err_q;
    assign w_accept      = cfg_valid && cfg_ready;
    assign w_any_applied = |w_applied;

    generate
        if (NUM_CH == (2 ** CH_W)) begin : g_full_sel
            assign w_bad = 1'b0;
        end else begin : g_partial_sel
            assign w_bad = (cfg_ch >= CH_W'(NUM_CH));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= w_accept && w_bad;
            if (w_accept && !w_bad) begin
                pend_vld_q <= 1'b1;
                pend_ch_q  <= cfg_ch;
                pend_div_q <= cfg_div;
            end else if (pend_vld_q && w_any_applied) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic w_apply_req;

            assign w_apply_req = pend_vld_q && (pend_ch_q == CH_W'(i));

            clk_en_channel #(
                .CNT_W   (CNT_W),
                .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
            ) u_channel (
                .clk         (clk),
                .rst         (rst),
                .run_i       (w_run),
                .realign_i   (realign),
                .apply_req_i (w_apply_req),
                .new_div_i   (pend_div_q),
                .ce_o        (ce[i]),
                .ce_mid_o    (ce_mid[i]),
                .div_o       (div_cur[i*CNT_W +: CNT_W]),
                .applied_o   (w_applied[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_enable_gen
//  Purpose  : Directed self-checking bench for clk_enable_gen (4- and 5-channel).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_enable_gen;

    localparam logic [31:0] c_DIV_INIT  = {8'd8, 8'd4, 8'd2, 8'd1};
    localparam logic [39:0] c_DIV_INIT5 = {8'd3, 8'd8, 8'd4, 8'd2, 8'd1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        realign = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [7:0]  cfg_div = '0;
    logic        cfg_ready;
    logic        cfg_err;
    logic        ready;
    logic [3:0]  ce;
    logic [3:0]  ce_mid;
    logic [31:0] div_cur;

    logic        cfg_valid5 = 1'b0;
    logic [2:0]  cfg_ch5 = '0;
    logic [7:0]  cfg_div5 = '0;
    logic        cfg_ready5;
    logic        cfg_err5;
    logic        ready5;
    logic [4:0]  ce5;
    logic [4:0]  ce_mid5;
    logic [39:0] div_cur5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    clk_enable_gen u_dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .realign    (realign),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_err    (cfg_err),
        .ready      (ready),
        .ce         (ce),
        .ce_mid     (ce_mid),
        .div_cur    (div_cur)
    );

    clk_enable_gen #(
        .NUM_CH   (5),
        .DIV_INIT (c_DIV_INIT5)
    ) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (1'b0),
        .realign    (1'b0),
        .cfg_valid  (cfg_valid5),
        .cfg_ready  (cfg_ready5),
        .cfg_ch     (cfg_ch5),
        .cfg_div    (cfg_div5),
        .cfg_err    (cfg_err5),
        .ready      (ready5),
        .ce         (ce5),
        .ce_mid     (ce_mid5),
        .div_cur    (div_cur5)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] ce_tab  [0:7];
        logic [3:0] mid_tab [0:7];
        int t_lock;
        int r;
        int s;

        ce_tab  = '{4'hF, 4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1};
        mid_tab = '{4'h0, 4'h2, 4'h4, 4'h2, 4'h8, 4'h2, 4'h4, 4'h2};

        // Reset state
        repeat (3) step();
        check_eq("rst_ready",     64'(ready),     64'(0));
        check_eq("rst_ce",        64'(ce),        64'(0));
        check_eq("rst_ce_mid",    64'(ce_mid),    64'(0));
        check_eq("rst_cfg_err",   64'(cfg_err),   64'(0));
        check_eq("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        check_eq("rst_div_cur",   64'(div_cur),   64'(c_DIV_INIT));
        check_eq("rst_div_cur5",  64'(div_cur5),  64'(c_DIV_INIT5));
        rst = 1'b0;
        step();

        // Lock-up: ready 18 edges after the first high sample of pll_locked
        pll_locked = 1'b1;
        t_lock = cyc;
        goto(t_lock + 18);
        check_eq("lock_ready_early", 64'(ready), 64'(0));
        check_eq("lock_ce_early",    64'(ce),    64'(0));
        goto(t_lock + 19);
        check_eq("lock_ready", 64'(ready), 64'(1));
        r = cyc;
        for (int k = 0; k < 8; k++) begin
            goto(r + k);
            check_eq($sformatf("run_ce_k%0d", k),  64'(ce),     64'(ce_tab[k]));
            check_eq($sformatf("run_mid_k%0d", k), 64'(ce_mid), 64'(mid_tab[k]));
        end

        // Glitch-free change: ch3 counter is 5 at r+11
        goto(r + 11);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        check_eq("gf_cfg_ready_low", 64'(cfg_ready),      64'(0));
        check_eq("gf_div_old",       64'(div_cur[31:24]), 64'(8));
        goto(r + 15);
        check_eq("gf_ce3_before", 64'(ce[3]), 64'(0));
        goto(r + 16);
        check_eq("gf_ce3_strobe", 64'(ce[3]),          64'(1));
        check_eq("gf_div_new",    64'(div_cur[31:24]), 64'(3));
        goto(r + 17);
        check_eq("gf_cfg_ready_back", 64'(cfg_ready), 64'(1));
        check_eq("gf_ce3_after",      64'(ce[3]),     64'(0));
        goto(r + 18);
        check_eq("gf_mid3_d3", 64'(ce_mid[3]), 64'(1));
        goto(r + 19);
        check_eq("gf_ce3_period3", 64'(ce[3]), 64'(1));

        // Channel off, then on; cfg_valid held while busy must be ignored
        goto(r + 20);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        step();
        cfg_ch = 2'd2; cfg_div = 8'd9;
        check_eq("off_cfg_ready_low", 64'(cfg_ready), 64'(0));
        step();
        cfg_valid = 1'b0;
        check_eq("off_apply_ce1", 64'(ce[1]),          64'(1));
        check_eq("off_div1",      64'(div_cur[15:8]),  64'(0));
        step();
        check_eq("off_ce1_quiet",  64'(ce[1]),     64'(0));
        check_eq("off_cfg_ready",  64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        check_eq("on_div1_applied", 64'(div_cur[15:8]), 64'(5));
        check_eq("on_ce1_apply",    64'(ce[1]),         64'(0));
        goto(r + 25);
        check_eq("on_cfg_ready", 64'(cfg_ready),       64'(1));
        check_eq("busy_ignored", 64'(div_cur[23:16]),  64'(4));
        goto(r + 28);
        check_eq("on_ce1_wait", 64'(ce[1]), 64'(0));
        goto(r + 29);
        check_eq("on_ce1_first", 64'(ce[1]), 64'(1));

        // Lock loss for 3 cycles
        goto(r + 30);
        pll_locked = 1'b0;
        goto(r + 32);
        check_eq("loss_ready_still", 64'(ready), 64'(1));
        goto(r + 33);
        pll_locked = 1'b1;
        check_eq("loss_ready", 64'(ready),  64'(0));
        check_eq("loss_ce",    64'(ce),     64'(0));
        check_eq("loss_mid",   64'(ce_mid), 64'(0));
        goto(r + 51);
        check_eq("relock_ready_early", 64'(ready), 64'(0));
        goto(r + 52);
        check_eq("relock_ready", 64'(ready),   64'(1));
        check_eq("relock_ce",    64'(ce),      64'(4'hF));
        check_eq("relock_div",   64'(div_cur), 64'(32'h0304_0501));

        // Build D={6,4,2,1} out of phase, then realign
        s = cyc;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        goto(s + 3);
        check_eq("ra_ce3_apply", 64'(ce[3]),          64'(1));
        check_eq("ra_div3",      64'(div_cur[31:24]), 64'(6));
        goto(s + 4);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0;
        check_eq("ra_div1", 64'(div_cur[15:8]), 64'(2));
        goto(s + 10);
        check_eq("ra_out_of_phase", 64'(ce), 64'(4'h1));
        realign = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        step();
        realign = 1'b0;
        cfg_valid = 1'b0;
        check_eq("ra_all_ce",     64'(ce),      64'(4'hF));
        check_eq("ra_pend_apply", 64'(div_cur), 64'(32'h0603_0201));
        goto(s + 14);
        check_eq("ra_mid3", 64'(ce_mid[3]), 64'(1));
        goto(s + 16);
        check_eq("ra_ce3_gap", 64'(ce[3]), 64'(0));
        goto(s + 17);
        check_eq("ra_ce_period6", 64'(ce), 64'(4'hF));

        // Reset with an update pending
        goto(s + 18);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        step();
        cfg_valid = 1'b0;
        check_eq("rstmid_pending", 64'(cfg_ready), 64'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstmid_div",       64'(div_cur),   64'(c_DIV_INIT));
        check_eq("rstmid_cfg_ready", 64'(cfg_ready), 64'(1));
        check_eq("rstmid_ready",     64'(ready),     64'(0));
        check_eq("rstmid_ce",        64'(ce),        64'(0));

        // Out-of-range channel on the 5-channel build
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd7; cfg_div5 = 8'h55;
        step();
        cfg_valid5 = 1'b0;
        check_eq("bad7_err",       64'(cfg_err5),   64'(1));
        check_eq("bad7_cfg_ready", 64'(cfg_ready5), 64'(1));
        check_eq("bad7_div",       64'(div_cur5),   64'(c_DIV_INIT5));
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd4; cfg_div5 = 8'd9;
        step();
        cfg_valid5 = 1'b0;
        check_eq("bad7_err_once",   64'(cfg_err5),         64'(0));
        check_eq("ch4_apply_idle",  64'(div_cur5[39:32]),  64'(9));
        check_eq("ch4_cfg_ready",   64'(cfg_ready5),       64'(0));
        cfg_valid5 = 1'b0;
        step();
        check_eq("ch4_cfg_ready_back", 64'(cfg_ready5), 64'(1));
        check_eq("ch4_no_err",         64'(cfg_err5),   64'(0));
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd5; cfg_div5 = 8'd1;
        step();
        cfg_valid5 = 1'b0;
        check_eq("bad5_err",       64'(cfg_err5),   64'(1));
        check_eq("bad5_cfg_ready", 64'(cfg_ready5), 64'(1));
        check_eq("bad5_div",       64'(div_cur5),   64'({8'd9, c_DIV_INIT5[31:0]}));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
